// File: rtl/lcd_hex_frame_driver.sv
// HD44780 write-only bus sequencer: power-up init, then shows a WIDTH-bit value as
// upper-case hex on line 1, with one-deep buffering of display updates.
module lcd_hex_frame_driver #(
    parameter int WIDTH         = 32,
    parameter int INIT_WAIT_CYC = 750000,
    parameter int E_PULSE_CYC   = 12,
    parameter int CMD_WAIT_CYC  = 2000,
    parameter int CLR_WAIT_CYC  = 80000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             update,
    output logic             busy,
    output logic             lcd_rs,
    output logic             lcd_rw,
    output logic             lcd_e,
    output logic [7:0]       lcd_d
);

    localparam int NCH = WIDTH / 4;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_HOME,
        ST_CHARS
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_STROBE,
        PH_WAIT
    } phase_t;

    state_t           r_state, w_state;
    phase_t           r_ph, w_ph;
    logic [31:0]      r_cnt, w_cnt;
    logic [4:0]       r_idx, w_idx;
    logic [7:0]       r_lcd_d, w_lcd_d;
    logic             r_lcd_rs, w_lcd_rs;
    logic             r_lcd_e, w_lcd_e;
    logic             r_pend, w_pend;
    logic [WIDTH-1:0] r_frame, w_frame;
    logic [WIDTH-1:0] r_pdata, w_pdata;

    logic [4:0]       w_idx_inc;
    logic             w_is_clr;
    logic             w_last;
    logic             w_refresh;
    logic [WIDTH-1:0] w_src;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return 8'h37 + {4'h0, n};
    endfunction

    // Character i of the frame, most significant nibble first.
    function automatic logic [3:0] nib(input logic [WIDTH-1:0] f, input logic [4:0] i);
        logic [WIDTH-1:0] s;
        s = f << {i, 2'b00};
        return s[WIDTH-1:WIDTH-4];
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_PWRUP;
            r_ph     <= PH_SETUP;
            r_cnt    <= 32'(INIT_WAIT_CYC - 1);
            r_idx    <= '0;
            r_lcd_d  <= 8'h00;
            r_lcd_rs <= 1'b0;
            r_lcd_e  <= 1'b0;
            r_pend   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_ph     <= w_ph;
            r_cnt    <= w_cnt;
            r_idx    <= w_idx;
            r_lcd_d  <= w_lcd_d;
            r_lcd_rs <= w_lcd_rs;
            r_lcd_e  <= w_lcd_e;
            r_pend   <= w_pend;
        end
    end

    always_ff @(posedge clk) begin
        r_frame <= w_frame;
        r_pdata <= w_pdata;
    end

    always_comb begin
        w_state   = r_state;
        w_ph      = r_ph;
        w_cnt     = r_cnt;
        w_idx     = r_idx;
        w_lcd_d   = r_lcd_d;
        w_lcd_rs  = r_lcd_rs;
        w_lcd_e   = r_lcd_e;
        w_pend    = r_pend;
        w_frame   = r_frame;
        w_pdata   = r_pdata;
        w_idx_inc = r_idx + 5'd1;
        w_is_clr  = (r_state == ST_INIT) && (r_idx == 5'd3);
        w_last    = w_is_clr || ((r_state == ST_CHARS) && (r_idx == 5'(NCH - 1)));
        // A request arriving in the same cycle as frame end is newer than the buffer.
        w_refresh = update || r_pend;
        w_src     = update ? data : r_pdata;

        if (update) begin
            if (r_state == ST_IDLE) begin
                w_frame = data;
            end else begin
                w_pdata = data;
                w_pend  = 1'b1;
            end
        end

        case (r_state)
            ST_PWRUP: begin
                if (r_cnt == '0) begin
                    w_state  = ST_INIT;
                    w_ph     = PH_SETUP;
                    w_idx    = '0;
                    w_lcd_d  = init_cmd(2'd0);
                    w_lcd_rs = 1'b0;
                end else begin
                    w_cnt = r_cnt - 32'd1;
                end
            end
            ST_IDLE: begin
                if (update) begin
                    w_state  = ST_HOME;
                    w_ph     = PH_SETUP;
                    w_lcd_d  = 8'h80;
                    w_lcd_rs = 1'b0;
                end
            end
            default: begin
                case (r_ph)
                    PH_SETUP: begin
                        w_ph    = PH_STROBE;
                        w_lcd_e = 1'b1;
                        w_cnt   = 32'(E_PULSE_CYC - 1);
                    end
                    PH_STROBE: begin
                        if (r_cnt == '0) begin
                            w_ph    = PH_WAIT;
                            w_lcd_e = 1'b0;
                            w_cnt   = w_is_clr ? 32'(CLR_WAIT_CYC - 1) : 32'(CMD_WAIT_CYC - 1);
                        end else begin
                            w_cnt = r_cnt - 32'd1;
                        end
                    end
                    default: begin
                        if (r_cnt != '0) begin
                            w_cnt = r_cnt - 32'd1;
                        end else begin
                            w_ph = PH_SETUP;
                            if (w_last) begin
                                if (w_refresh) begin
                                    w_frame  = w_src;
                                    w_pend   = 1'b0;
                                    w_state  = ST_HOME;
                                    w_lcd_d  = 8'h80;
                                    w_lcd_rs = 1'b0;
                                end else begin
                                    w_state = ST_IDLE;
                                end
                            end else if (r_state == ST_INIT) begin
                                w_idx   = w_idx_inc;
                                w_lcd_d = init_cmd(w_idx_inc[1:0]);
                            end else if (r_state == ST_HOME) begin
                                w_state  = ST_CHARS;
                                w_idx    = '0;
                                w_lcd_d  = hex_char(nib(r_frame, 5'd0));
                                w_lcd_rs = 1'b1;
                            end else begin
                                w_idx   = w_idx_inc;
                                w_lcd_d = hex_char(nib(r_frame, w_idx_inc));
                            end
                        end
                    end
                endcase
            end
        endcase
    end

    assign busy   = (r_state != ST_IDLE) || r_pend;
    assign lcd_rs = r_lcd_rs;
    assign lcd_rw = 1'b0;
    assign lcd_e  = r_lcd_e;
    assign lcd_d  = r_lcd_d;

endmodule
